// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master Wishbone classic arbiter onto one slave port, with
// alternating tie-break, cyc-held ownership and a stall timeout that ends a transfer with err.
module wb_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    sys_clk,
   input  logic                    rst_n,
   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
   input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_dat_i,
   output logic [DATA_WIDTH-1:0]   m0_dat_o,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
   input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_dat_i,
   output logic [DATA_WIDTH-1:0]   m1_dat_o,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [DATA_WIDTH/8-1:0] s_sel_o,
   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   input  logic                    s_ack_i,
   output logic [1:0]              grant_o,
   output logic [7:0]              timeout_cnt_o
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [15:0] stall_q, stall_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic        req0, req1, own0, own1, cyc_x, stb_x, timeout;
   assign req0    = m0_cyc_i & m0_stb_i;
   assign req1    = m1_cyc_i & m1_stb_i;
   assign own0    = state_q == OWN0;
   assign own1    = state_q == OWN1;
   assign cyc_x   = own0 ? m0_cyc_i : own1 & m1_cyc_i;
   assign stb_x   = own0 ? m0_stb_i : own1 & m1_stb_i;
   assign timeout = cyc_x & stb_x & ~s_ack_i & (stall_q == TO_LAST);
   // last_q = 1 means m1 was granted last, so m0 wins the next tie
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req0 & req1 ? (last_q ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
         OWN0:    state_d = m0_cyc_i ? OWN0 : req1 ? OWN1 : IDLE;
         OWN1:    state_d = m1_cyc_i ? OWN1 : req0 ? OWN0 : IDLE;
         default: state_d = IDLE;
      endcase
      last_d  = (state_d == OWN0 && !own0) ? 1'b0 : (state_d == OWN1 && !own1) ? 1'b1 : last_q;
      stall_d = (state_d != state_q || !cyc_x || !stb_x || s_ack_i || timeout) ? '0 : stall_q + 16'd1;
      tcnt_d  = (timeout && tcnt_q != 8'hFF) ? tcnt_q + 8'd1 : tcnt_q;
   end
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         stall_q <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         stall_q <= stall_d;
         tcnt_q  <= tcnt_d;
      end
   assign s_cyc_o       = cyc_x;
   assign s_stb_o       = stb_x & ~timeout;
   assign s_we_o        = own0 ? m0_we_i : own1 & m1_we_i;
   assign s_sel_o       = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
   assign s_adr_o       = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
   assign s_dat_o       = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
   assign m0_dat_o      = own0 ? s_dat_i : '0;
   assign m1_dat_o      = own1 ? s_dat_i : '0;
   assign m0_ack_o      = own0 & s_ack_i;
   assign m1_ack_o      = own1 & s_ack_i;
   assign m0_err_o      = own0 & timeout;
   assign m1_err_o      = own1 & timeout;
   assign grant_o       = {own1, own0};
   assign timeout_cnt_o = tcnt_q;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: directed scenario tasks plus a randomized invariant scoreboard
// for wb_mem_arbiter built with TIMEOUT_CYCLES=8.
module tb_wb_mem_arbiter;
   logic        sys_clk = 1'b0, rst_n = 1'b0;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i;
   logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
   logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;
   logic [1:0]  grant_o;
   logic [7:0]  timeout_cnt_o;
   int          total = 0, bad = 0;

   wb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge
   task automatic nxt;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic smp;
      @(negedge sys_clk);
   endtask

   task automatic quiet;
      {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
      {m0_sel_i, m1_sel_i} = '0;
      {m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i} = '0;
   endtask

   task automatic do_reset;
      quiet();
      #2 rst_n = 1'b0;
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      quiet();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      smp();
      total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got %b want 00", grant_o); end
      total++; if (timeout_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_tcnt got %0d want 0", timeout_cnt_o); end
      total++; if ({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o} !== 4'b0) begin bad++; $display("FAIL reset_outs got %b want 0000", {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o}); end
      do_reset();
   endtask

   task automatic test_single_read;
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_sel_i = 4'hF; m0_adr_i = 32'h100;
      smp();
      total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rd_grant_req got %b want 00", grant_o); end
      nxt(); smp();
      total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL rd_grant got %b want 01", grant_o); end
      total++; if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o} !== {3'b110, 32'h100}) begin bad++; $display("FAIL rd_slave got %b %h want 110 00000100", {s_cyc_o, s_stb_o, s_we_o}, s_adr_o); end
      total++; if (m0_ack_o !== 1'b0) begin bad++; $display("FAIL rd_early_ack got %b want 0", m0_ack_o); end
      nxt();
      s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
      smp();
      total++; if ({m0_ack_o, m0_dat_o} !== {1'b1, 32'hCAFEF00D}) begin bad++; $display("FAIL rd_data got %b %h want 1 cafef00d", m0_ack_o, m0_dat_o); end
      total++; if ({m1_ack_o, m1_err_o, m1_dat_o} !== 34'd0) begin bad++; $display("FAIL rd_m1_quiet got %b %b %h want 0 0 0", m1_ack_o, m1_err_o, m1_dat_o); end
      nxt();
      quiet();
      nxt(); smp();
      total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rd_release got %b want 00", grant_o); end
   endtask

   task automatic test_tie_handover;
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'hA0;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'hB0;
      nxt(); smp();
      total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tie1_grant got %b want 01", grant_o); end
      s_ack_i = 1'b1;
      smp();
      total++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin bad++; $display("FAIL tie1_ack got %b want 10", {m0_ack_o, m1_ack_o}); end
      nxt();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      smp();
      total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL handover_pre got %b want 01", grant_o); end
      nxt(); smp();
      total++; if ({grant_o, s_adr_o} !== {2'b10, 32'hB0}) begin bad++; $display("FAIL handover got %b %h want 10 000000b0", grant_o, s_adr_o); end
      s_ack_i = 1'b1;
      nxt();
      s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      nxt();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      smp();
      total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL tie2_idle got %b want 00", grant_o); end
      nxt(); smp();
      total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL tie2_grant got %b want 01", grant_o); end
      nxt();
      quiet();
      nxt();
   endtask

   task automatic test_burst;
      logic [31:0] beat;
      do_reset();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'h3; m1_adr_i = 32'h200; m1_dat_i = 32'h11;
      nxt();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h300;
      smp();
      total++; if ({grant_o, s_we_o, s_sel_o, s_dat_o} !== {2'b10, 1'b1, 4'h3, 32'h11}) begin bad++; $display("FAIL burst_start got %b %b %h %h want 10 1 3 00000011", grant_o, s_we_o, s_sel_o, s_dat_o); end
      for (int i = 0; i < 4; i++) begin
         beat = 32'hD000 + 32'(i);
         m1_dat_i = beat; m1_adr_i = 32'h200 + 32'(4 * i); s_ack_i = 1'b1;
         smp();
         total++; if ({grant_o, m1_ack_o, m0_ack_o, s_dat_o} !== {2'b10, 2'b10, beat}) begin bad++; $display("FAIL burst_beat%0d got %b %b%b %h want 10 10 %h", i, grant_o, m1_ack_o, m0_ack_o, s_dat_o, beat); end
         nxt();
      end
      s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      smp();
      total++; if ({grant_o, m0_ack_o} !== 3'b100) begin bad++; $display("FAIL burst_end got %b %b want 10 0", grant_o, m0_ack_o); end
      nxt(); smp();
      total++; if ({grant_o, s_adr_o} !== {2'b01, 32'h300}) begin bad++; $display("FAIL burst_m0 got %b %h want 01 00000300", grant_o, s_adr_o); end
      s_ack_i = 1'b1;
      nxt();
      quiet();
      nxt();
   endtask

   task automatic test_timeout;
      int pulses = 0;
      do_reset();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h400;
      for (int k = 0; k < 8; k++) begin
         nxt(); smp();
         pulses += int'(m1_err_o);
         total++; if ({grant_o, m1_err_o, s_stb_o, m0_err_o, m1_ack_o} !== {2'b10, k == 7, k != 7, 2'b00}) begin bad++; $display("FAIL timeout_c%0d got %b %b %b want 10 %b %b", k, grant_o, m1_err_o, s_stb_o, k == 7, k != 7); end
         total++; if (timeout_cnt_o !== 8'd0) begin bad++; $display("FAIL timeout_cnt_c%0d got %0d want 0", k, timeout_cnt_o); end
      end
      nxt(); smp();
      pulses += int'(m1_err_o);
      total++; if ({timeout_cnt_o, s_stb_o, m1_err_o} !== {8'd1, 2'b10}) begin bad++; $display("FAIL timeout_after got %0d %b %b want 1 1 0", timeout_cnt_o, s_stb_o, m1_err_o); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
      nxt();
      quiet();
      nxt();
   endtask

   task automatic test_async_reset;
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h500;
      nxt(); smp();
      total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL ar_grant got %b want 01", grant_o); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({grant_o, s_cyc_o, s_stb_o, s_adr_o} !== 36'd0) begin bad++; $display("FAIL ar_zero got %b %b %b %h want 00 0 0 0", grant_o, s_cyc_o, s_stb_o, s_adr_o); end
      s_ack_i = 1'b1; s_dat_i = 32'h1234;
      #1;
      total++; if ({m0_ack_o, m0_err_o, m0_dat_o} !== 34'd0) begin bad++; $display("FAIL ar_noack got %b %b %h want 0 0 0", m0_ack_o, m0_err_o, m0_dat_o); end
      nxt();
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      rst_n = 1'b1;
      nxt(); smp();
      total++; if ({grant_o, m0_ack_o, m1_ack_o, m0_dat_o} !== 36'd0) begin bad++; $display("FAIL ar_late_ack got %b %b %b %h want 00 0 0 0", grant_o, m0_ack_o, m1_ack_o, m0_dat_o); end
      quiet();
      nxt();
   endtask

   task automatic test_random;
      logic [1:0] pg;
      logic       pc0, pc1;
      do_reset();
      smp();
      pg = grant_o; pc0 = m0_cyc_i; pc1 = m1_cyc_i;
      for (int n = 0; n < 300; n++) begin
         nxt();
         if (m0_cyc_i) begin if ($urandom_range(3) == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end end
         else if ($urandom_range(2) == 0) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = $urandom; end
         if (m1_cyc_i) begin if ($urandom_range(3) == 0) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end end
         else if ($urandom_range(2) == 0) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = $urandom; end
         s_ack_i = 1'($urandom_range(1)); s_dat_i = $urandom;
         smp();
         total++; if (grant_o == 2'b11) begin bad++; $display("FAIL rnd_onehot n=%0d got %b want 00/01/10", n, grant_o); end
         total++; if ((m0_ack_o & m0_err_o) | (m1_ack_o & m1_err_o)) begin bad++; $display("FAIL rnd_ack_err n=%0d got %b%b %b%b want no both-high", n, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o); end
         total++; if (((pg == 2'b01 && pc0) || (pg == 2'b10 && pc1)) && grant_o !== pg) begin bad++; $display("FAIL rnd_hold n=%0d got %b want %b", n, grant_o, pg); end
         total++; if ({m0_ack_o, m1_ack_o} !== ({grant_o[0], grant_o[1]} & {2{s_ack_i}})) begin bad++; $display("FAIL rnd_ack n=%0d got %b%b grant %b s_ack %b", n, m0_ack_o, m1_ack_o, grant_o, s_ack_i); end
         pg = grant_o; pc0 = m0_cyc_i; pc1 = m1_cyc_i;
      end
      quiet();
      nxt();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie_handover();
      test_burst();
      test_timeout();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
